// File: rtl/coa_ctrl_pkg.sv
// ============================================================================
// Package : coa_ctrl_pkg
// Brief   : Opcodes, state/class encodings and control-word type for ctrl_fsm.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package coa_ctrl_pkg;

    localparam logic [5:0] OPC_RTYPE   = 6'h00;
    localparam logic [5:0] OPC_IALU_LO = 6'h01;
    localparam logic [5:0] OPC_IALU_HI = 6'h0F;
    localparam logic [5:0] OPC_BEQZ    = 6'h10;
    localparam logic [5:0] OPC_BNEZ    = 6'h11;
    localparam logic [5:0] OPC_J       = 6'h12;
    localparam logic [5:0] OPC_JAL     = 6'h13;
    localparam logic [5:0] OPC_HALT    = 6'h3F;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        WB     = 3'd3,
        HALTED = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_IALU    = 3'd1,
        CLS_BEQZ    = 3'd2,
        CLS_BNEZ    = 3'd3,
        CLS_J       = 3'd4,
        CLS_JAL     = 3'd5,
        CLS_HALT    = 3'd6,
        CLS_ILLEGAL = 3'd7
    } opc_class_t;

    typedef struct packed {
        logic we;
        logic oprnd1_sel;
        logic oprnd2_sel;
        logic rd_sel;
        logic din_sel2;
        logic extn_cntl;
        logic next_pc;
        logic pc_en;
        logic ir_en;
        logic illegal;
    } ctrl_out_t;

    function automatic opc_class_t opc_to_class(input logic [5:0] opc);
        opc_class_t cls;
        if (opc == OPC_RTYPE)                            cls = CLS_RTYPE;
        else if (opc >= OPC_IALU_LO && opc <= OPC_IALU_HI) cls = CLS_IALU;
        else if (opc == OPC_BEQZ)                        cls = CLS_BEQZ;
        else if (opc == OPC_BNEZ)                        cls = CLS_BNEZ;
        else if (opc == OPC_J)                           cls = CLS_J;
        else if (opc == OPC_JAL)                         cls = CLS_JAL;
        else if (opc == OPC_HALT)                        cls = CLS_HALT;
        else                                             cls = CLS_ILLEGAL;
        return cls;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_fsm_opcode_class_dec.sv
// ============================================================================
// Module  : opcode_class_dec
// Brief   : Combinational opcode -> instruction class decoder (shared with monitor).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module opcode_class_dec
    import coa_ctrl_pkg::*;
(
    input  logic [5:0]  opcode,
    output opc_class_t  cls
);

    assign cls = opc_to_class(opcode);

endmodule

`default_nettype wire

// File: rtl/ctrl_fsm.sv
// ============================================================================
// Module  : ctrl_fsm
// Brief   : Step-gated FETCH/DECODE/EXEC/WB control unit with registered outputs.
//           Optional INSTR_CNT_EN adds a retired-instruction counter port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_fsm
    import coa_ctrl_pkg::*;
#(
    parameter int OPC_W = 6
`ifdef INSTR_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic [31:0]       IR,
    input  logic              RS1is0,
    output logic              WE,
    output logic              Oprnd1Sel,
    output logic              Oprnd2Sel,
    output logic              RDSEL,
    output logic              DinSel2,
    output logic              ExtnCntl,
    output logic              NextPC,
    output logic              PCen,
    output logic              IRen,
    output logic              halted,
    output logic              illegal
`ifdef INSTR_CNT_EN
    ,
    output logic [CNT_W-1:0]  instr_cnt
`endif
);

    state_t     r_state, w_state_nxt;
    opc_class_t r_cls, w_cls_nxt, w_cls_dec;
    logic       r_taken, w_taken_nxt;
    logic       r_halted, w_halted_nxt;
    ctrl_out_t  r_out, w_out_nxt, w_sel;
    logic       w_adv;
    logic       w_unused_ir;

    assign w_unused_ir = ^IR[31-OPC_W:0];

    opcode_class_dec u_dec (
        .opcode (IR[31:32-OPC_W]),
        .cls    (w_cls_dec)
    );

    // HALTED is terminal until reset, so steps there are swallowed.
    assign w_adv = step && (r_state != HALTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= FETCH;
            r_cls    <= CLS_RTYPE;
            r_taken  <= 1'b0;
            r_halted <= 1'b0;
            r_out    <= '0;
        end else if (w_adv) begin
            r_state  <= w_state_nxt;
            r_cls    <= w_cls_nxt;
            r_taken  <= w_taken_nxt;
            r_halted <= w_halted_nxt;
            r_out    <= w_out_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cls_nxt    = r_cls;
        w_taken_nxt  = r_taken;
        w_halted_nxt = r_halted;
        w_out_nxt    = '0;
        w_sel        = '0;

        // Operand selects stay valid through WB so the written ALU result is stable.
        unique case (r_cls)
            CLS_IALU: w_sel.oprnd2_sel = 1'b1;
            CLS_BEQZ, CLS_BNEZ: begin
                w_sel.oprnd1_sel = 1'b1;
                w_sel.oprnd2_sel = 1'b1;
            end
            CLS_J, CLS_JAL: begin
                w_sel.oprnd1_sel = 1'b1;
                w_sel.oprnd2_sel = 1'b1;
                w_sel.extn_cntl  = 1'b1;
            end
            default: ;
        endcase

        unique case (r_state)
            FETCH: begin
                w_out_nxt.ir_en = 1'b1;
                w_state_nxt     = DECODE;
            end
            DECODE: begin
                w_cls_nxt         = w_cls_dec;
                w_taken_nxt       = ((w_cls_dec == CLS_BEQZ) &&  RS1is0) ||
                                    ((w_cls_dec == CLS_BNEZ) && !RS1is0);
                w_out_nxt.illegal = (w_cls_dec == CLS_ILLEGAL);
                if (w_cls_dec == CLS_HALT) begin
                    w_state_nxt  = HALTED;
                    w_halted_nxt = 1'b1;
                end else begin
                    w_state_nxt  = EXEC;
                end
            end
            EXEC: begin
                w_out_nxt   = w_sel;
                w_state_nxt = WB;
            end
            WB: begin
                w_out_nxt          = w_sel;
                w_out_nxt.pc_en    = 1'b1;
                w_out_nxt.next_pc  = (r_cls == CLS_J) || (r_cls == CLS_JAL) || r_taken;
                w_out_nxt.we       = (r_cls == CLS_RTYPE) || (r_cls == CLS_IALU) ||
                                     (r_cls == CLS_JAL);
                w_out_nxt.rd_sel   = (r_cls == CLS_RTYPE) || (r_cls == CLS_JAL);
                w_out_nxt.din_sel2 = (r_cls == CLS_RTYPE) || (r_cls == CLS_IALU);
                w_state_nxt        = FETCH;
            end
            HALTED: ;
            default: w_state_nxt = FETCH;
        endcase
    end

`ifdef INSTR_CNT_EN
    logic [CNT_W-1:0] r_instr_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_cnt <= '0;
        end else if (w_adv && (r_state == WB)) begin
            r_instr_cnt <= r_instr_cnt + 1'b1;
        end
    end

    assign instr_cnt = r_instr_cnt;
`endif

    assign WE        = r_out.we;
    assign Oprnd1Sel = r_out.oprnd1_sel;
    assign Oprnd2Sel = r_out.oprnd2_sel;
    assign RDSEL     = r_out.rd_sel;
    assign DinSel2   = r_out.din_sel2;
    assign ExtnCntl  = r_out.extn_cntl;
    assign NextPC    = r_out.next_pc;
    assign PCen      = r_out.pc_en;
    assign IRen      = r_out.ir_en;
    assign illegal   = r_out.illegal;
    assign halted    = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_fsm.sv
// ============================================================================
// Module  : tb_ctrl_fsm
// Brief   : Randomized self-checking bench for ctrl_fsm against an
//           instruction-level model of the control outputs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        step;
    logic [31:0] IR;
    logic        RS1is0;
    logic        WE, Oprnd1Sel, Oprnd2Sel, RDSEL, DinSel2, ExtnCntl;
    logic        NextPC, PCen, IRen, halted, illegal;
`ifdef INSTR_CNT_EN
    logic [31:0] instr_cnt;
`endif

    ctrl_fsm u_dut (
        .clk       (clk),
        .rst       (rst),
        .step      (step),
        .IR        (IR),
        .RS1is0    (RS1is0),
        .WE        (WE),
        .Oprnd1Sel (Oprnd1Sel),
        .Oprnd2Sel (Oprnd2Sel),
        .RDSEL     (RDSEL),
        .DinSel2   (DinSel2),
        .ExtnCntl  (ExtnCntl),
        .NextPC    (NextPC),
        .PCen      (PCen),
        .IRen      (IRen),
        .halted    (halted),
        .illegal   (illegal)
`ifdef INSTR_CNT_EN
        ,
        .instr_cnt (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [10:0] m_exp;
    bit          m_halted;
    int unsigned m_cnt;

    // Bit order: WE,Oprnd1Sel,Oprnd2Sel,RDSEL,DinSel2,ExtnCntl,NextPC,PCen,IRen,halted,illegal
    logic [10:0] w_obs;
    assign w_obs = {WE, Oprnd1Sel, Oprnd2Sel, RDSEL, DinSel2, ExtnCntl,
                    NextPC, PCen, IRen, halted, illegal};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected outputs after the ph-th step of one instruction (1..4).
    function automatic logic [10:0] exp_vec(input int ph, input logic [5:0] op, input bit rs0);
        bit is_r, is_i, bz, bn, j, jl, hlt, ill, brj;
        logic [10:0] v;
        is_r = (op == 6'd0);
        is_i = (op >= 6'd1) && (op <= 6'd15);
        bz   = (op == 6'd16);
        bn   = (op == 6'd17);
        j    = (op == 6'd18);
        jl   = (op == 6'd19);
        hlt  = (op == 6'd63);
        ill  = !(is_r || is_i || bz || bn || j || jl || hlt);
        brj  = bz || bn || j || jl;
        v = '0;
        if (ph == 1) v[2] = 1'b1;
        if (ph == 2) v[0] = ill;
        if (ph >= 3) begin
            v[9] = brj;
            v[8] = is_i || brj;
            v[5] = j || jl;
        end
        if (ph == 4) begin
            v[10] = is_r || is_i || jl;
            v[7]  = is_r || jl;
            v[6]  = is_r || is_i;
            v[4]  = j || jl || (bz && rs0) || (bn && !rs0);
            v[3]  = 1'b1;
        end
        return v;
    endfunction

    task automatic check_outs(input string tag);
        chk(tag, 32'(w_obs), 32'(m_exp | (m_halted ? 11'd2 : 11'd0)));
`ifdef INSTR_CNT_EN
        chk({tag, "_cnt"}, instr_cnt, m_cnt);
`endif
    endtask

    task automatic do_step();
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
    endtask

    task automatic do_reset(input bit with_step);
        step = with_step;
        rst  = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        step     = 1'b0;
        m_exp    = '0;
        m_halted = 1'b0;
        m_cnt    = 0;
        check_outs("reset");
    endtask

    task automatic run_instr(input logic [5:0] op, input bit rs0, input bit toggle,
                             input int abort_ph, input bit long_gap);
        int g;
        IR     = {op, 26'($urandom)};
        RS1is0 = rs0;
        for (int ph = 1; ph <= 4; ph++) begin
            g = long_gap ? 10 : int'($urandom_range(0, 3));
            if (g > 0) begin
                repeat (g) @(posedge clk);
                #1;
                check_outs("hold");
            end
            if (ph == abort_ph) begin
                do_reset(1'b1);
                return;
            end
            do_step();
            m_exp = exp_vec(ph, op, rs0);
            if (ph == 2) begin
                if (op == 6'h3F) m_halted = 1'b1;
                if (toggle) RS1is0 = ~RS1is0;
                IR = $urandom;
            end
            if (ph == 4) m_cnt++;
            check_outs($sformatf("op%02h_ph%0d", op, ph));
            if (m_halted) begin
                for (int k = 0; k < 20; k++) begin
                    do_step();
                    check_outs("halted_step");
                end
                do_reset(1'b0);
                return;
            end
        end
    endtask

    initial begin
        logic [5:0] op;
        rst    = 1'b1;
        step   = 1'b0;
        IR     = 32'h0;
        RS1is0 = 1'b0;
        m_exp  = '0;
        m_halted = 1'b0;
        m_cnt  = 0;
        repeat (3) @(posedge clk);
        #1;
        do_reset(1'b0);

        // Directed scenarios
        run_instr(6'h00, 1'b0, 1'b0, 0, 1'b0);
        run_instr(6'h01, 1'b0, 1'b0, 0, 1'b1);
        run_instr(6'h10, 1'b1, 1'b0, 0, 1'b0);
        run_instr(6'h10, 1'b0, 1'b0, 0, 1'b0);
        run_instr(6'h10, 1'b1, 1'b1, 0, 1'b0);
        run_instr(6'h11, 1'b0, 1'b1, 0, 1'b0);
        run_instr(6'h13, 1'b0, 1'b0, 0, 1'b0);
        run_instr(6'h2A, 1'b0, 1'b0, 0, 1'b0);
        run_instr(6'h12, 1'b1, 1'b0, 0, 1'b0);
        run_instr(6'h00, 1'b0, 1'b0, 3, 1'b0);
        run_instr(6'h00, 1'b0, 1'b0, 0, 1'b0);
        run_instr(6'h05, 1'b1, 1'b0, 0, 1'b0);
        run_instr(6'h13, 1'b0, 1'b0, 0, 1'b0);
        run_instr(6'h3F, 1'b0, 1'b0, 0, 1'b0);

        // Randomized instruction stream
        for (int n = 0; n < 120; n++) begin
            case ($urandom_range(0, 7))
                0:       op = 6'h00;
                1:       op = 6'($urandom_range(1, 15));
                2:       op = 6'h10;
                3:       op = 6'h11;
                4:       op = 6'h12;
                5:       op = 6'h13;
                6:       op = ($urandom_range(0, 3) == 0) ? 6'h3F : 6'h00;
                default: op = 6'($urandom_range(20, 62));
            endcase
            run_instr(op, 1'($urandom), 1'($urandom),
                      ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 4)) : 0,
                      1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
